// File: rtl/clause_row_if.sv
// rtl/clause_row_if.sv - implication/conflict handshake between a clause row and the base cells
//
// Purpose : bundles the valid/ready handshake and the per-slot value bus that a
//           clause row drives towards the variable base cells.
// Ports   : imp_valid_o  - implication or conflict mark presented (clause row -> cells)
//           imp_ready_i  - cells accept the presented value        (cells -> clause row)
//           var_value_o  - 2 bits per slot: 00 none, 10 true, 01 false, 11 conflict
// Modports: master = clause row, slave = consumer.
interface clause_row_if #(
   parameter int NUM_LIT = 8
);
   logic                   imp_valid_o;
   logic                   imp_ready_i;
   logic [2*NUM_LIT-1:0]   var_value_o;

   modport master (
      output imp_valid_o,
      output var_value_o,
      input  imp_ready_i
   );

   modport slave (
      input  imp_valid_o,
      input  var_value_o,
      output imp_ready_i
   );
endinterface

// File: rtl/clause_row.sv
// rtl/clause_row.sv - one clause of a hardware SAT engine: evaluate, imply a unit literal or flag a conflict
//
// Purpose : holds the literal polarities of one clause, evaluates it against the
//           current variable values and either reports sat/undecided, drives the
//           single remaining free literal as an implication, or marks a conflict.
// Ports   : clk, rst          - clock, synchronous active-low reset
//           wr_i, var_value_i - load polarities (IDLE only) / per-slot variable values
//           start_i           - begin one evaluation pass
//           imp               - clause_row_if.master: imp_valid_o, imp_ready_i, var_value_o
//           done_o            - one-cycle end-of-pass pulse
//           sat_o, unit_o, conflict_o, free_cnt_o - results, updated in DONE
//           bt_i, bt_level_i, cur_level_i - backtrack strobe and decision levels
// Option  : CLAUSE_ROW_LEVEL_EN - store the decision level of each implication so a
//           backtrack only clears implications made above bt_level_i. Undefined:
//           every backtrack clears all implied flags and the level inputs are unused.
module clause_row #(
   parameter  int NUM_LIT = 8,
   parameter  int LVL_W   = 4,
   localparam int CNT_W   = $clog2(NUM_LIT + 1),
   localparam int IDX_W   = $clog2(NUM_LIT)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wr_i,
   input  logic [2*NUM_LIT-1:0] var_value_i,
   input  logic                 start_i,
   clause_row_if.master         imp,
   output logic                 done_o,
   output logic                 sat_o,
   output logic                 unit_o,
   output logic                 conflict_o,
   output logic [CNT_W-1:0]     free_cnt_o,
   input  logic                 bt_i,
   input  logic [LVL_W-1:0]     bt_level_i,
   input  logic [LVL_W-1:0]     cur_level_i
);

   typedef enum logic [2:0] {IDLE, EVAL, IMPLY, CONFL, DONE} state_t;

   state_t                    state, state_n, eval_tgt;
   logic [NUM_LIT-1:0][1:0]   pol;
   logic [NUM_LIT-1:0]        imp_flag;
   logic [IDX_W-1:0]          idx_r, idx_c;
   logic [CNT_W-1:0]          cnt_r, cnt_c;
   logic                      res_sat, res_unit, res_confl;
   logic                      sat_c, part_c, iconf_c, found_c;
   logic [2*NUM_LIT-1:0]      vv;

`ifdef CLAUSE_ROW_LEVEL_EN
   logic [NUM_LIT-1:0][LVL_W-1:0] lvl;
`else
   logic unused_levels;
   assign unused_levels = ^{bt_level_i, cur_level_i};
`endif

   // Clause evaluation against the live variable values; only registered in EVAL.
   always_comb begin
      sat_c   = 1'b0;
      part_c  = 1'b0;
      iconf_c = 1'b0;
      found_c = 1'b0;
      cnt_c   = '0;
      idx_c   = '0;
      for (int i = 0; i < NUM_LIT; i++) begin
         if (pol[i] != 2'b00) begin
            part_c = 1'b1;
            if (var_value_i[2*i +: 2] == pol[i])
               sat_c = 1'b1;
            if (var_value_i[2*i +: 2] == 2'b00) begin
               cnt_c = cnt_c + CNT_W'(1);
               if (!found_c) begin
                  idx_c   = IDX_W'(i);
                  found_c = 1'b1;
               end
            end
         end
         // A literal this row implied that has since been marked conflicting
         // overrides every other outcome.
         if (imp_flag[i] && var_value_i[2*i +: 2] == 2'b11)
            iconf_c = 1'b1;
      end
   end

   always_comb begin
      eval_tgt = CONFL;
      if (iconf_c)
         eval_tgt = CONFL;
      else if (!part_c || sat_c || cnt_c >= CNT_W'(2))
         eval_tgt = DONE;
      else if (cnt_c == CNT_W'(1))
         eval_tgt = IMPLY;

      state_n = state;
      case (state)
         IDLE:    if (start_i) state_n = EVAL;
         EVAL:    state_n = eval_tgt;
         IMPLY:   if (imp.imp_ready_i) state_n = DONE;
         CONFL:   if (imp.imp_ready_i) state_n = DONE;
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
      if (bt_i && state != IDLE)
         state_n = IDLE;
   end

   // Presented values depend only on pol (frozen outside IDLE) and idx_r
   // (frozen outside EVAL), so they hold while the consumer stalls.
   always_comb begin
      vv = '0;
      for (int i = 0; i < NUM_LIT; i++) begin
         if (state == IMPLY && IDX_W'(i) == idx_r)
            vv[2*i +: 2] = pol[i];
         if (state == CONFL && pol[i] != 2'b00)
            vv[2*i +: 2] = 2'b11;
      end
   end

   assign imp.var_value_o = vv;
   assign imp.imp_valid_o = (state == IMPLY) || (state == CONFL);
   assign done_o          = (state == DONE);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         pol        <= '0;
         imp_flag   <= '0;
         idx_r      <= '0;
         cnt_r      <= '0;
         res_sat    <= 1'b0;
         res_unit   <= 1'b0;
         res_confl  <= 1'b0;
         sat_o      <= 1'b0;
         unit_o     <= 1'b0;
         conflict_o <= 1'b0;
         free_cnt_o <= '0;
`ifdef CLAUSE_ROW_LEVEL_EN
         lvl        <= '0;
`endif
      end else begin
         state <= state_n;

         if (state == IDLE && wr_i) begin
            for (int i = 0; i < NUM_LIT; i++)
               pol[i] <= (var_value_i[2*i +: 2] == 2'b11) ? 2'b00 : var_value_i[2*i +: 2];
            imp_flag <= '0;
         end

         if (state == EVAL) begin
            idx_r     <= idx_c;
            cnt_r     <= cnt_c;
            res_sat   <= sat_c && !iconf_c;
            res_unit  <= (eval_tgt == IMPLY);
            res_confl <= (eval_tgt == CONFL);
         end

         // Backtrack takes precedence over an accept in the same cycle.
         if (bt_i) begin
`ifdef CLAUSE_ROW_LEVEL_EN
            for (int i = 0; i < NUM_LIT; i++)
               if (lvl[i] > bt_level_i)
                  imp_flag[i] <= 1'b0;
`else
            imp_flag <= '0;
`endif
         end else if (state == IMPLY && imp.imp_ready_i) begin
            imp_flag[idx_r] <= 1'b1;
`ifdef CLAUSE_ROW_LEVEL_EN
            lvl[idx_r]      <= cur_level_i;
`endif
         end

         if (state == DONE) begin
            sat_o      <= res_sat;
            unit_o     <= res_unit;
            conflict_o <= res_confl;
            free_cnt_o <= cnt_r;
         end
      end
   end

endmodule

// File: doc/clause_row.md
CLAUSE_ROW -- requirements
Module: clause_row

Interface
REQ-001 The block SHALL have parameter NUM_LIT, default 8: number of literal cells in the clause row, legal range 2..32.
REQ-002 The block SHALL have parameter LVL_W, default 4: width of the decision-level field.
REQ-003 The block SHALL have port clk  input  1  clock; reset rst, synchronous, active-low.
REQ-004 The block SHALL have port rst  input  1  synchronous active-low reset.
REQ-005 The block SHALL have port wr_i  input  1  load literal polarities from var_value_i.
REQ-006 The block SHALL have port var_value_i  input  2*NUM_LIT  per-slot value: 00 free, 10 true, 01 false, 11 conflict-marked.
REQ-007 The block SHALL have port start_i  input  1  begin one evaluation pass.
REQ-008 The block SHALL have port imp_valid_o  output  1  implication or conflict mark is presented on var_value_o.
REQ-009 The block SHALL have port imp_ready_i  input  1  consumer accepts the presented implication or mark.
REQ-010 The block SHALL have port var_value_o  output  2*NUM_LIT  per-slot value driven to the base cells.
REQ-011 The block SHALL have port done_o  output  1  one-cycle pulse marking the end of a pass.
REQ-012 The block SHALL have port sat_o, unit_o, conflict_o  output  1 each  registered pass results.
REQ-013 The block SHALL have port free_cnt_o  output  $clog2(NUM_LIT+1)  registered count of free participating literals.
REQ-014 The block SHALL have port bt_i  input  1  backtrack strobe.
REQ-015 The block SHALL have port bt_level_i  input  LVL_W  backtrack target level (used only with CLAUSE_ROW_LEVEL_EN).
REQ-016 The block SHALL have port cur_level_i  input  LVL_W  current decision level (used only with CLAUSE_ROW_LEVEL_EN).

Function
REQ-017 Polarity encoding SHALL be pol[i] = 10 positive, 01 negative, 00 not participating; 11 SHALL be stored as 00.
REQ-018 When wr_i is high in IDLE, pol[i] SHALL capture var_value_i[i] and all implied flags SHALL clear; wr_i SHALL be ignored outside IDLE.
REQ-019 Literal i SHALL be satisfied when pol[i]!=00 and value[i]==pol[i], and SHALL be free when pol[i]!=00 and value[i]==00.
REQ-020 The FSM SHALL have states IDLE, EVAL, IMPLY, CONFL and DONE.
REQ-021 IDLE SHALL go to EVAL on start_i; start_i SHALL be ignored in all other states.
REQ-022 EVAL SHALL take exactly 1 cycle and SHALL register sat, free_cnt and the index of the lowest-numbered free literal.
REQ-023 From EVAL the FSM SHALL go to DONE if sat=1 or free_cnt>=2.
REQ-024 From EVAL the FSM SHALL go to IMPLY if sat=0 and free_cnt==1.
REQ-025 From EVAL the FSM SHALL go to CONFL if sat=0 and free_cnt==0 with at least one participating literal.
REQ-026 From EVAL the FSM SHALL go to DONE if the clause has no participating literal, with every result flag 0.
REQ-027 An implied-literal conflict SHALL take priority over REQ-023..026: any slot with implied flag set and value 11 SHALL send the FSM to CONFL.
REQ-028 In IMPLY, imp_valid_o SHALL be 1 and var_value_o[unit] SHALL equal pol[unit], with all other slots 00.
REQ-029 On imp_valid_o & imp_ready_i in IMPLY, the implied flag of the unit slot SHALL set and the FSM SHALL go to DONE.
REQ-030 In CONFL, imp_valid_o SHALL be 1 and every participating slot SHALL drive 11, others 00.
REQ-031 On imp_valid_o & imp_ready_i in CONFL, the FSM SHALL go to DONE.
REQ-032 imp_valid_o and var_value_o SHALL hold stable while imp_ready_i is low.
REQ-033 DONE SHALL last 1 cycle, SHALL pulse done_o, and SHALL return to IDLE.
REQ-034 sat_o, unit_o, conflict_o and free_cnt_o SHALL update in DONE and SHALL hold until the next DONE.
REQ-035 bt_i SHALL be honoured in any state: it clears implied flags per REQ-040/041, and outside IDLE it SHALL abort the pass to IDLE without a done_o pulse.
REQ-036 When bt_i and imp_ready_i are high in the same cycle, bt_i SHALL win and no implied flag SHALL set.

Reset
REQ-037 When rst=0 at a clk edge, the FSM SHALL go to IDLE and pol and implied flags SHALL clear.
REQ-038 During and after reset all outputs SHALL be 0: var_value_o=0, imp_valid_o=0, done_o=0, sat_o=0, unit_o=0, conflict_o=0, free_cnt_o=0.
REQ-039 Reset mid-handshake SHALL drop imp_valid_o in the following cycle, with no flag set.

Configuration
REQ-040 With CLAUSE_ROW_LEVEL_EN defined, each slot SHALL store cur_level_i when its implied flag sets, and bt_i SHALL clear only flags whose stored level > bt_level_i.
REQ-041 Without CLAUSE_ROW_LEVEL_EN, bt_i SHALL clear all implied flags, no level storage SHALL exist, and bt_level_i and cur_level_i SHALL be ignored.

Verification
REQ-042 Scenario: NUM_LIT=4, load pol {10,01,00,10}, values {01,10,00,00}, start -> IMPLY; slot3 drives 10; after ready, unit_o=1, free_cnt_o=1, done_o pulses 1 cycle.
REQ-043 Scenario: same pol, values {10,00,00,00}, start -> no imp_valid_o; DONE 2 cycles after start with sat_o=1.
REQ-044 Scenario: all participating slots false, start -> CONFL; participating slots drive 11; conflict_o=1 after ready.
REQ-045 Scenario: imply slot3 at level 3, then value 11 on slot3, start -> CONFL via implied-conflict priority, even with a second literal free.
REQ-046 Scenario: imp_ready_i held low 5 cycles in IMPLY -> outputs stable; assert bt_i -> IDLE, no done_o, implied flag clear.
REQ-047 Scenario (LEVEL_EN): flags at levels 2 and 5, bt_i with bt_level_i=3 -> only the level-5 flag clears; rst=0 mid-IMPLY -> all outputs 0 next cycle.
